// File: rtl/key_cmd_decoder.sv
// key_cmd_decoder: debounces WASD HID keycodes on frame ticks, emits
// direction, held flag, one-cycle move pulses and a press counter.
// Ports: Clk, Reset (sync, active-high), keycode[7:0], frame_clk (VGA vs)
//   -> dir[1:0], dir_valid, move_pulse, press_count[7:0].
// Define KEY_AUTOREPEAT_EN to add the REPEAT state and auto-repeat pulses.
module key_cmd_decoder #(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int REPEAT_DELAY    = 15,
  parameter int REPEAT_RATE     = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_clk,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       move_pulse,
  output logic [7:0] press_count
);

  localparam logic [3:0] DB_N = DEBOUNCE_FRAMES[3:0];
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [5:0] RD_N = REPEAT_DELAY[5:0];
  localparam logic [5:0] RR_N = REPEAT_RATE[5:0];
`endif

`ifdef KEY_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    IDLE, DEBOUNCE, HELD, REPEAT
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, DEBOUNCE, HELD
  } state_t;
`endif

  state_t      state;
  logic [7:0]  kc_q;
  logic        fc_q;
  logic [7:0]  cand;
  logic [3:0]  dcnt;
`ifdef KEY_AUTOREPEAT_EN
  logic [5:0]  rcnt;
`endif
  logic        tick;
  logic        go_held;

  function automatic logic key_ok(input logic [7:0] k);
    case (k)
      8'h1A, 8'h04, 8'h16, 8'h07: key_ok = 1'b1;
      default:                    key_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] key_dir(input logic [7:0] k);
    case (k)
      8'h1A:   key_dir = 2'b00;
      8'h04:   key_dir = 2'b01;
      8'h16:   key_dir = 2'b10;
      8'h07:   key_dir = 2'b11;
      default: key_dir = 2'b00;
    endcase
  endfunction

  assign tick = frame_clk & ~fc_q;

  // Acceptance: either straight from IDLE (single-frame debounce)
  // or when the debounce count reaches its target.
  // In both cases kc_q is the key being accepted.
  always_comb begin
    go_held = 1'b0;
    if (tick) begin
      if (state == IDLE)
        go_held = key_ok(kc_q) && (DB_N == 4'd1);
      else if (state == DEBOUNCE)
        go_held = (kc_q == cand) && (dcnt + 4'd1 == DB_N);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      kc_q        <= 8'h00;
      fc_q        <= 1'b0;
      cand        <= 8'h00;
      dcnt        <= 4'd0;
`ifdef KEY_AUTOREPEAT_EN
      rcnt        <= 6'd0;
`endif
      dir         <= 2'b00;
      dir_valid   <= 1'b0;
      move_pulse  <= 1'b0;
      press_count <= 8'h00;
    end else begin
      kc_q       <= keycode;
      fc_q       <= frame_clk;
      move_pulse <= 1'b0;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (key_ok(kc_q)) begin
              cand  <= kc_q;
              dcnt  <= 4'd1;
              state <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (kc_q != cand)
              state <= IDLE;
            else
              dcnt <= dcnt + 4'd1;
          end
          HELD: begin
            if (kc_q != cand) begin
              state     <= IDLE;
              dir_valid <= 1'b0;
            end
`ifdef KEY_AUTOREPEAT_EN
            else if (rcnt + 6'd1 == RD_N) begin
              move_pulse <= 1'b1;
              rcnt       <= 6'd0;
              state      <= REPEAT;
            end else begin
              rcnt <= rcnt + 6'd1;
            end
`endif
          end
`ifdef KEY_AUTOREPEAT_EN
          REPEAT: begin
            if (kc_q != cand) begin
              state     <= IDLE;
              dir_valid <= 1'b0;
            end else if (rcnt + 6'd1 == RR_N) begin
              move_pulse <= 1'b1;
              rcnt       <= 6'd0;
            end else begin
              rcnt <= rcnt + 6'd1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
        // Entry into HELD overrides the DEBOUNCE/IDLE next-state above.
        if (go_held) begin
          state       <= HELD;
          dir         <= key_dir(kc_q);
          dir_valid   <= 1'b1;
          move_pulse  <= 1'b1;
          press_count <= press_count + 8'd1;
`ifdef KEY_AUTOREPEAT_EN
          rcnt        <= 6'd0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_key_cmd_decoder.sv
// tb_key_cmd_decoder: directed and random frame-tick stimulus for
// key_cmd_decoder, compared against a run-length model of key holds.
module tb_key_cmd_decoder;

  localparam int DB = 2;
  localparam int RD = 15;
  localparam int RR = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       frame_clk;
  logic [1:0] dir;
  logic       dir_valid;
  logic       move_pulse;
  logic [7:0] press_count;

  key_cmd_decoder #(
    .DEBOUNCE_FRAMES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .keycode(keycode),
    .frame_clk(frame_clk),
    .dir(dir),
    .dir_valid(dir_valid),
    .move_pulse(move_pulse),
    .press_count(press_count)
  );

  always #10 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  int pulses_seen = 0;

  // Model: length of the current run of identical valid keys seen on
  // ticks; a mismatch ends the run and that tick starts nothing.
  logic [7:0] m_key = 8'h00;
  int         m_len = 0;
  logic [1:0] m_dir = 2'b00;
  logic [7:0] m_cnt = 8'h00;
  logic       m_pulse = 1'b0;

  function automatic logic valid_k(input logic [7:0] k);
    return (k == 8'h1A) || (k == 8'h04) || (k == 8'h16) || (k == 8'h07);
  endfunction

  function automatic logic [1:0] dir_of(input logic [7:0] k);
    if (k == 8'h1A) return 2'd0;
    if (k == 8'h04) return 2'd1;
    if (k == 8'h16) return 2'd2;
    return 2'd3;
  endfunction

  task automatic model_tick(input logic [7:0] k);
    m_pulse = 1'b0;
    if (m_len > 0 && k == m_key) m_len++;
    else if (m_len > 0) m_len = 0;
    else if (valid_k(k)) begin
      m_key = k;
      m_len = 1;
    end
    if (m_len == DB) begin
      m_pulse = 1'b1;
      m_cnt   = m_cnt + 8'd1;
      m_dir   = dir_of(m_key);
    end
`ifdef KEY_AUTOREPEAT_EN
    if (m_len >= DB + RD && ((m_len - DB - RD) % RR) == 0)
      m_pulse = 1'b1;
`endif
  endtask

  task automatic model_reset();
    m_key = 8'h00; m_len = 0; m_dir = 2'b00;
    m_cnt = 8'h00; m_pulse = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_pulse"}, {31'd0, move_pulse}, {31'd0, m_pulse});
    chk({tag, "_valid"}, {31'd0, dir_valid}, {31'd0, m_len >= DB});
    chk({tag, "_dir"},   {30'd0, dir},       {30'd0, m_dir});
    chk({tag, "_count"}, {24'd0, press_count}, {24'd0, m_cnt});
  endtask

  task automatic do_tick(input logic [7:0] k);
    @(negedge Clk) keycode = k;
    @(negedge Clk) frame_clk = 1'b1;
    model_tick(k);
    @(posedge Clk) #1;
    chk_all("tick");
    if (move_pulse === 1'b1) pulses_seen++;
    @(negedge Clk) frame_clk = 1'b0;
    @(posedge Clk) #1;
    chk("nontick_pulse", {31'd0, move_pulse}, 32'd0);
  endtask

  // Reset asserted on the same edge as a frame tick.
  task automatic reset_on_tick();
    @(negedge Clk) begin
      Reset = 1'b1;
      frame_clk = 1'b1;
    end
    model_reset();
    @(posedge Clk) #1;
    chk_all("rst_tick");
    @(negedge Clk) begin
      Reset = 1'b0;
      frame_clk = 1'b0;
    end
  endtask

  logic [7:0] pool [6];
  logic [7:0] k;
  int         exp_rep;

  initial begin
    pool[0] = 8'h1A; pool[1] = 8'h04; pool[2] = 8'h16;
    pool[3] = 8'h07; pool[4] = 8'h00; pool[5] = 8'h55;
    Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    chk_all("reset");
    @(negedge Clk) Reset = 1'b0;

    // Held right key: accepted on tick 2.
    do_tick(8'h07);
    do_tick(8'h07);
    chk("d_dir_right", {30'd0, dir}, 32'd3);
    chk("d_count_1", {24'd0, press_count}, 32'd1);
    do_tick(8'h07);
    do_tick(8'h00);

    // Single-frame tap is rejected.
    do_tick(8'h1A);
    do_tick(8'h00);
    chk("tap_count", {24'd0, press_count}, 32'd1);

    // Long hold of left key.
    pulses_seen = 0;
    for (int i = 0; i < 40; i++) do_tick(8'h04);
`ifdef KEY_AUTOREPEAT_EN
    exp_rep = 7;
`else
    exp_rep = 1;
`endif
    chk("hold40_pulses", pulses_seen, exp_rep);
    do_tick(8'h00);

    // Direct key switch counts as release then new press.
    repeat (3) do_tick(8'h16);
    do_tick(8'h07);
    chk("switch_valid", {31'd0, dir_valid}, 32'd0);
    do_tick(8'h07);
    do_tick(8'h07);
    chk("switch_dir", {30'd0, dir}, 32'd3);
    chk("switch_count", {24'd0, press_count}, 32'd4);
    do_tick(8'h00);

    // Reset during debounce, coincident with a tick.
    do_tick(8'h1A);
    reset_on_tick();
    @(posedge Clk) #1;
    chk("post_rst_pulse", {31'd0, move_pulse}, 32'd0);
    chk("post_rst_count", {24'd0, press_count}, 32'd0);
    do_tick(8'h1A);
    do_tick(8'h1A);
    do_tick(8'h00);

    // Counter wrap.
    reset_on_tick();
    for (int i = 0; i < 256; i++) begin
      do_tick(8'h1A);
      do_tick(8'h1A);
      do_tick(8'h00);
    end
    chk("wrap_count", {24'd0, press_count}, 32'd0);

    // Random key streams, biased to hold the previous key.
    k = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) k = pool[$urandom_range(0, 5)];
      do_tick(k);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_cmd_decoder.md
KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_FRAMES, default 2, meaning consecutive frame ticks a keycode must be stable before acceptance (legal 1..15).
REQ-002 SHALL have parameter REPEAT_DELAY, default 15, meaning frame ticks from acceptance to first auto-repeat pulse (legal 1..63).
REQ-003 SHALL have parameter REPEAT_RATE, default 4, meaning frame ticks between subsequent auto-repeat pulses (legal 1..63).
REQ-004 SHALL have port Clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port keycode  input  8  USB HID keycode from Nios PIO export; 0x00 = no key.
REQ-007 SHALL have port frame_clk  input  1  VGA vs, synchronous to Clk; rising edge = frame tick.
REQ-008 SHALL have port dir  output  2  direction: 00 up (W, 0x1A), 01 left (A, 0x04), 10 down (S, 0x16), 11 right (D, 0x07).
REQ-009 SHALL have port dir_valid  output  1  high while an accepted direction key is held.
REQ-010 SHALL have port move_pulse  output  1  one-Clk-cycle pulse commanding one motion step.
REQ-011 SHALL have port press_count  output  8  count of accepted presses, wraps 0xFF->0x00.

Function
REQ-012 SHALL register keycode into kc_q and frame_clk into fc_q every cycle; tick = frame_clk & ~fc_q.
REQ-013 SHALL treat kc_q as a valid key only for values 0x1A, 0x04, 0x16, 0x07; all others, incl. 0x00, equal "no key".
REQ-014 SHALL change state, counters or outputs (except the sampling registers) only on tick cycles; move_pulse SHALL be 0 on every non-tick cycle.
REQ-015 SHALL implement FSM states IDLE, DEBOUNCE, HELD, REPEAT.
REQ-016 IDLE: on tick with valid kc_q, SHALL latch cand<=kc_q, dcnt<=1; go DEBOUNCE, or HELD directly if DEBOUNCE_FRAMES==1.
REQ-017 DEBOUNCE: on tick, kc_q!=cand SHALL go IDLE; else dcnt++, and reaching DEBOUNCE_FRAMES SHALL go HELD.
REQ-018 Entry into HELD SHALL, in the same cycle, set dir<=decode(cand), dir_valid<=1, move_pulse<=1 for one cycle, press_count++, rcnt<=0.
REQ-019 HELD: on tick, kc_q!=cand SHALL go IDLE with dir_valid<=0; else rcnt++, and rcnt reaching REPEAT_DELAY SHALL pulse move_pulse, rcnt<=0, go REPEAT.
REQ-020 REPEAT: on tick, kc_q!=cand SHALL go IDLE with dir_valid<=0; else rcnt++, and reaching REPEAT_RATE SHALL pulse move_pulse, rcnt<=0.
REQ-021 dir SHALL retain its last value after release; it is meaningful only while dir_valid=1.
REQ-022 A direct change from one valid key to another while HELD/REPEAT SHALL count as release (IDLE on that tick) followed by a fresh press debounced from the next tick.
REQ-023 move_pulse SHALL be a registered output, asserted in the cycle after the tick-sampling edge.

Reset
REQ-024 Reset=1 at a rising Clk edge SHALL force state IDLE, dir=00, dir_valid=0, move_pulse=0, press_count=0x00, cand=0x00, dcnt=0, rcnt=0, kc_q=0x00, fc_q=0.
REQ-025 Reset SHALL take priority over a simultaneous tick; reset mid-press SHALL abandon the press without a pulse or count.

Configuration
REQ-026 With macro KEY_AUTOREPEAT_EN defined, REPEAT state and rcnt SHALL exist as in REQ-019..020.
REQ-027 Without KEY_AUTOREPEAT_EN, HELD SHALL only detect release; exactly one move_pulse per accepted press; REPEAT_DELAY/REPEAT_RATE unused.

Verification
REQ-028 keycode=0x07 held 3 ticks (defaults) -> on tick 2: dir=11, dir_valid=1, one move_pulse, press_count=0x01.
REQ-029 keycode=0x1A for 1 tick then 0x00 -> no move_pulse, dir_valid=0, press_count=0x00.
REQ-030 keycode=0x04 held 40 ticks, AUTOREPEAT on -> pulses at ticks 2, 17, 21, 25, 29, 33, 37 (7 total); without macro -> 1 pulse.
REQ-031 0x16 accepted, then switch to 0x07 -> IDLE and dir_valid=0 on switch tick, dir=11 and dir_valid=1 two ticks later, press_count+2 total.
REQ-032 Reset asserted during DEBOUNCE coincident with a tick -> all outputs at reset values next cycle, no pulse.
REQ-033 256 accepted presses of 0x1A -> press_count wraps to 0x00.
